// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - state type and default parameters for the tail light sequencer
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } statetype;

  localparam int NLAMP_DEFAULT    = 3;
  localparam int TICK_DIV_DEFAULT = 1;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing one step pulse every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // With TICK_DIV=1 LAST is zero, so step stays high every cycle.
  assign step = (count == LAST);

endmodule

// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - sequential turn/hazard/brake tail light controller
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int NLAMP    = NLAMP_DEFAULT,
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [NLAMP-1:0] lamps_l,
  output logic [NLAMP-1:0] lamps_r,
  output logic             busy
);

  localparam int IW = $clog2(NLAMP + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NLAMP);

  logic             step;
  logic             haz_req;
  statetype         state, nxt_state;
  logic [IW-1:0]    idx, nxt_idx;
  logic [NLAMP-1:0] pat, brk, nxt_l, nxt_r;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .step  (step)
  );

  assign haz_req = hazard | (left & right);

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    if (step) begin
      case (state)
        IDLE: begin
          if (haz_req) begin
            nxt_state = HAZ_ON;
            nxt_idx   = '0;
          end else if (left) begin
            nxt_state = LEFT;
            nxt_idx   = IW'(1);
          end else if (right) begin
            nxt_state = RIGHT;
            nxt_idx   = IW'(1);
          end
        end
        LEFT, RIGHT: begin
          // Turn input is ignored here so a started sequence always completes.
          if (haz_req) begin
            nxt_state = HAZ_ON;
            nxt_idx   = '0;
          end else if (idx == IDX_LAST) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + IW'(1);
          end
        end
        HAZ_ON: begin
          nxt_state = HAZ_OFF;
          nxt_idx   = '0;
        end
        HAZ_OFF: begin
          nxt_state = haz_req ? HAZ_ON : IDLE;
          nxt_idx   = '0;
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = '0;
        end
      endcase
    end
  end

  // Lamps decode from the next state so the pattern appears right after the step edge.
  always_comb begin
    pat = '0;
    for (int i = 0; i < NLAMP; i++) begin
      pat[i] = (i < int'(nxt_idx));
    end
    brk   = brake ? '1 : '0;
    nxt_l = '0;
    nxt_r = '0;
    case (nxt_state)
      IDLE:    begin nxt_l = brk; nxt_r = brk; end
      LEFT:    begin nxt_l = pat; nxt_r = brk; end
      RIGHT:   begin nxt_l = brk; nxt_r = pat; end
      HAZ_ON:  begin nxt_l = '1;  nxt_r = '1;  end
      default: begin nxt_l = '0;  nxt_r = '0;  end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      lamps_l <= '0;
      lamps_r <= '0;
    end else begin
      state   <= nxt_state;
      idx     <= nxt_idx;
      lamps_l <= nxt_l;
      lamps_r <= nxt_r;
    end
  end

  assign busy = (state != IDLE);

endmodule
